// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder for digit/row select.
//
// Direct mode captures a binary index on a load strobe and decodes it. Scan
// mode steps through every output on its own, holding each one for dwell+1
// cycles, and pulses wrap when the index rolls over from OUT_W-1 to 0.
//
// Optional build macro:
//   DECODER_SCAN_BLANK_EN - anti-ghosting blanking. In scan mode with
//   dwell >= 1, Out is forced to zero for the first cycle of every dwell
//   period. Index, the dwell counter and wrap timing are unaffected.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   enable  in   0 blanks outputs (idle), 1 runs the selected mode
//   mode    in   0 = direct, 1 = scan
//   In      in   binary index (direct mode only)
//   load    in   direct-mode capture strobe for In
//   dwell   in   cycles per output minus one (scan mode)
//   Out     out  registered one-hot select, all-zero when blank
//   Index   out  registered current index
//   wrap    out  one-cycle pulse on scan rollover to index 0
module decoder_scan #(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [IN_W-1:0]      In,
  input  logic                 load,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**IN_W-1:0]   Out,
  output logic [IN_W-1:0]      Index,
  output logic                 wrap
);

  localparam int unsigned OUT_W = 2 ** IN_W;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDirect = 2'd1;
  localparam logic [1:0] StScan   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IN_W-1:0]    index_q, index_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               show;

  always_comb begin
    // Mode is re-evaluated every edge; load never competes with scan entry.
    if (!enable)   state_d = StIdle;
    else if (mode) state_d = StScan;
    else           state_d = StDirect;

    index_d = index_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    show    = 1'b0;

    case (state_d)
      StDirect: begin
        if (load) index_d = In;
        cnt_d = '0;
        show  = 1'b1;
      end
      StScan: begin
        show = 1'b1;
        if (state_q != StScan) begin
          // Fresh entry starts a full dwell period at the current index.
          cnt_d = '0;
        end else if (cnt_q >= dwell) begin
          // >= so a dwell lowered below cnt advances at once instead of
          // counting through the full range.
          cnt_d   = '0;
          index_d = index_q + 1'b1;
          wrap_d  = &index_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef DECODER_SCAN_BLANK_EN
        if ((dwell != '0) && (cnt_d == '0)) show = 1'b0;
`endif
      end
      default: ;
    endcase

    out_d = show ? ({{(OUT_W-1){1'b0}}, 1'b1} << index_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Out   = out_q;
  assign Index = index_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan (IN_W=3, DWELL_W=4). The stimulus process
// drives inputs on the falling edge and queues the response expected after the
// next rising edge; the monitor pops and compares shortly after each rising
// edge.
module tb_decoder_scan;

`ifdef DECODER_SCAN_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [2:0] in_b;
  logic       load;
  logic [3:0] dwell;
  logic [7:0] out_w;
  logic [2:0] index_w;
  logic       wrap_w;

  decoder_scan #(
    .IN_W    (3),
    .DWELL_W (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .In     (in_b),
    .load   (load),
    .dwell  (dwell),
    .Out    (out_w),
    .Index  (index_w),
    .wrap   (wrap_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o;
    logic [2:0] i;
    logic       w;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (out_w !== mon_e.o || index_w !== mon_e.i || wrap_w !== mon_e.w) begin
        errors++;
        $display("FAIL %s: got Out=%h Index=%0d wrap=%b, expected Out=%h Index=%0d wrap=%b",
                 mon_e.nm, out_w, index_w, wrap_w, mon_e.o, mon_e.i, mon_e.w);
      end
    end
  end

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit m, input bit ld,
                     input logic [2:0] inv, input logic [3:0] dw,
                     input logic [7:0] eo, input logic [2:0] ei, input bit ew,
                     input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; enable = e; mode = m; load = ld; in_b = inv; dwell = dw;
    x.o = eo; x.i = ei; x.w = ew; x.nm = nm;
    sb.push_back(x);
  endtask

  // One scan cycle; first marks the edge that starts a dwell period.
  task automatic scn(input logic [3:0] dw, input int idx, input bit first,
                     input bit ew, input string nm);
    logic [7:0] eo;
    eo = (Blank && first && dw != 4'd0) ? 8'h00 : oh(idx);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, dw, eo, 3'(idx), ew, nm);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; mode = 1'b1; in_b = '0; load = 1'b0; dwell = 4'd2;

    // Reset held with scan requested.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h00, 3'd0, 1'b0, "reset0");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h00, 3'd0, 1'b0, "reset1");

    // Scan dwell=2: two frames, wrap only on rollover into index 0.
    for (int f = 0; f < 2; f++)
      for (int idx = 0; idx < 8; idx++)
        for (int k = 0; k < 3; k++)
          scn(4'd2, idx, k == 0, (f > 0) && (idx == 0) && (k == 0), "scan_dw2");

    // Direct mode load and hold.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 4'd2, 8'h20, 3'd5, 1'b0, "direct_load5");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'd2, 8'h20, 3'd5, 1'b0, "direct_hold_a");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 4'd2, 8'h20, 3'd5, 1'b0, "direct_hold_b");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 4'd2, 8'h08, 3'd3, 1'b0, "direct_load3");

    // Load on the same edge as the switch to scan: load is ignored.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 4'd0, 8'h08, 3'd3, 1'b0, "scan_beats_load");

    // dwell=0: advance every edge, wrap every 8.
    for (int i = 0; i < 16; i++)
      scn(4'd0, (4 + i) % 8, 1'b1, ((4 + i) % 8) == 0, "scan_dw0");

    // dwell=9, count up to 5, then drop dwell to 1: advance on the next edge.
    for (int i = 0; i < 5; i++) scn(4'd9, 3, 1'b0, 1'b0, "scan_dw9_hold");
    scn(4'd1, 4, 1'b1, 1'b0, "dwell_lowered_adv");
    scn(4'd1, 4, 1'b0, 1'b0, "dw1_hold4");
    scn(4'd1, 5, 1'b1, 1'b0, "dw1_adv5");
    scn(4'd1, 5, 1'b0, 1'b0, "dw1_hold5");
    scn(4'd1, 6, 1'b1, 1'b0, "dw1_adv6");

    // Disable at index 6, then re-enable scan with a full dwell.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd2, 8'h00, 3'd6, 1'b0, "idle_blank0");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 4'd2, 8'h00, 3'd6, 1'b0, "idle_blank1");
    scn(4'd2, 6, 1'b1, 1'b0, "reenable_entry");
    scn(4'd2, 6, 1'b0, 1'b0, "reenable_hold1");
    scn(4'd2, 6, 1'b0, 1'b0, "reenable_hold2");
    scn(4'd2, 7, 1'b1, 1'b0, "reenable_adv7");

    // dwell=3: four cycles per index (first one blank when blanking is built in).
    for (int k = 1; k < 4; k++) scn(4'd3, 7, 1'b0, 1'b0, "scan_dw3_idx7");
    for (int idx = 0; idx < 3; idx++)
      for (int k = 0; k < 4; k++)
        scn(4'd3, idx, k == 0, (idx == 0) && (k == 0), "scan_dw3");

    // Reset mid-scan aborts with no wrap, then scan restarts at index 0.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1, 8'h00, 3'd0, 1'b0, "reset_midscan");
    scn(4'd1, 0, 1'b1, 1'b0, "post_reset_entry");
    scn(4'd1, 0, 1'b0, 1'b0, "post_reset_hold");
    scn(4'd1, 1, 1'b1, 1'b0, "post_reset_adv");

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
